// File: rtl/prog_pkg.sv
// Shared definitions for the 9-bit instruction format used by Control and the image writer.
// Contents: opcode enumeration, field positions, writer FSM state type, and the
// legality and encoding helpers.
package prog_pkg;

    localparam int INSTR_W  = 9;
    localparam int OPND_MSB = 8;
    localparam int OPND_LSB = 5;
    localparam int OP_MSB   = 4;
    localparam int OP_LSB   = 1;

    typedef enum logic [3:0] {
        OP_LDI = 4'd0,
        OP_LDM = 4'd1,
        OP_STM = 4'd2,
        OP_ADD = 4'd3,
        OP_SUB = 4'd4,
        OP_XOR = 4'd5,
        OP_OR  = 4'd6,
        OP_AND = 4'd7,
        OP_JMP = 4'd8,
        OP_BEQ = 4'd9,
        OP_BLT = 4'd10,
        OP_BGT = 4'd11,
        OP_LS  = 4'd12,
        OP_RS  = 4'd13
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WRITE  = 3'd2,
        ST_RDBK   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } wr_state_e;

    // Opcodes 14 and 15 have no meaning to Control.
    function automatic logic is_legal(input logic [3:0] op);
        return (op <= OP_RS);
    endfunction

    // Packs operand and opcode into the instruction word; bit 0 is always zero.
    function automatic logic [INSTR_W-1:0] encode(input logic [3:0] op,
                                                  input logic [3:0] operand);
        logic [INSTR_W-1:0] w;
        w                    = {INSTR_W{1'b0}};
        w[OPND_MSB:OPND_LSB] = operand;
        w[OP_MSB:OP_LSB]     = op;
        w[0]                 = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational instruction encoder.
// Ports: op, operand (4 bits each) in; word (9-bit instruction) and legal flag out.
module instr_encode
    import prog_pkg::*;
(
    input  logic [3:0]         op,
    input  logic [3:0]         operand,
    output logic [INSTR_W-1:0] word,
    output logic               legal
);

    assign word  = encode(op, operand);
    assign legal = is_legal(op);

endmodule

// File: rtl/prog_image_writer.sv
// Program image writer: accepts (opcode, operand) records on a valid/ready stream,
// encodes each into the 9-bit instruction format and writes them to consecutive
// imem addresses starting at base_addr, optionally reading back each word.
// Ports: clk/reset (sync, active-high); start/base_addr begin an image;
// in_valid/in_ready/in_op/in_operand/in_last record stream; mem_we/mem_re/mem_addr/
// mem_wdata/mem_rdata imem port; busy/done/err_illegal/err_verify/err_full status;
// words_written count of words written since start.
module prog_image_writer
    import prog_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int VERIFY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_op,
    input  logic [3:0]         in_operand,
    input  logic               in_last,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               mem_re,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               busy,
    output logic               done,
    output logic               err_illegal,
    output logic               err_verify,
    output logic               err_full,
    output logic [ADDR_W:0]    words_written
);

    localparam bit              VERIFY_EN = (VERIFY != 32'sd0);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    wr_state_e          state_r, state_s;
    logic [ADDR_W-1:0]  addr_r, addr_s, addr_inc_s;
    logic               full_r, full_s, at_top_s;
    logic [INSTR_W-1:0] word_r, word_s;
    logic               last_r, last_s;
    logic [INSTR_W-1:0] enc_word_s;
    logic               enc_legal_s;
    logic               hs_s;

    logic               in_ready_r, in_ready_s;
    logic               mem_we_r, mem_we_s;
    logic               mem_re_r, mem_re_s;
    logic [ADDR_W-1:0]  mem_addr_r, mem_addr_s;
    logic [INSTR_W-1:0] mem_wdata_r, mem_wdata_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               err_illegal_r, err_illegal_s;
    logic               err_verify_r, err_verify_s;
    logic               err_full_r, err_full_s;
    logic [ADDR_W:0]    words_r, words_s;

    instr_encode u_enc (
        .op      (in_op),
        .operand (in_operand),
        .word    (enc_word_s),
        .legal   (enc_legal_s)
    );

    assign hs_s = in_valid & in_ready_r;

    // The address register saturates at the top of memory; full_r then marks that
    // the last location has been consumed so the next record overflows.
    assign at_top_s   = (addr_r == LAST_ADDR);
    assign addr_inc_s = at_top_s ? addr_r : (addr_r + {{(ADDR_W-1){1'b0}}, 1'b1});

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_s = ST_ACCEPT;
                end else begin
                    state_s = state_r;
                end
            end
            ST_ACCEPT: begin
                if (hs_s) begin
                    if (!enc_legal_s || full_r) begin
                        state_s = ST_ERR;
                    end else if (VERIFY_EN) begin
                        state_s = ST_WRITE;
                    end else if (in_last) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ACCEPT;
                    end
                end else begin
                    state_s = ST_ACCEPT;
                end
            end
            ST_WRITE: state_s = ST_RDBK;
            ST_RDBK:  state_s = ST_CHECK;
            ST_CHECK: begin
                if (mem_rdata != word_r) begin
                    state_s = ST_ERR;
                end else if (last_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ACCEPT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output and datapath next values; everything here is registered below so the
    // status outputs line up with the state they describe.
    always_comb begin
        addr_s        = addr_r;
        full_s        = full_r;
        word_s        = word_r;
        last_s        = last_r;
        mem_we_s      = 1'b0;
        mem_re_s      = 1'b0;
        mem_addr_s    = mem_addr_r;
        mem_wdata_s   = mem_wdata_r;
        err_illegal_s = err_illegal_r;
        err_verify_s  = err_verify_r;
        err_full_s    = err_full_r;
        words_s       = words_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    addr_s        = base_addr;
                    full_s        = 1'b0;
                    err_illegal_s = 1'b0;
                    err_verify_s  = 1'b0;
                    err_full_s    = 1'b0;
                    words_s       = {(ADDR_W+1){1'b0}};
                end else begin
                    addr_s = addr_r;
                end
            end
            ST_ACCEPT: begin
                if (hs_s) begin
                    if (!enc_legal_s) begin
                        err_illegal_s = 1'b1;
                    end else if (full_r) begin
                        err_full_s = 1'b1;
                    end else begin
                        mem_we_s    = 1'b1;
                        mem_addr_s  = addr_r;
                        mem_wdata_s = enc_word_s;
                        words_s     = words_r + {{ADDR_W{1'b0}}, 1'b1};
                        word_s      = enc_word_s;
                        last_s      = in_last;
                        // Write-only mode advances immediately; verify mode waits for CHECK.
                        if (!VERIFY_EN) begin
                            addr_s = addr_inc_s;
                            full_s = at_top_s;
                        end else begin
                            addr_s = addr_r;
                        end
                    end
                end else begin
                    addr_s = addr_r;
                end
            end
            ST_WRITE: mem_re_s = 1'b1;
            ST_RDBK:  mem_re_s = 1'b0;
            ST_CHECK: begin
                if (mem_rdata != word_r) begin
                    err_verify_s = 1'b1;
                end else if (!last_r) begin
                    addr_s = addr_inc_s;
                    full_s = at_top_s;
                end else begin
                    addr_s = addr_r;
                end
            end
            default: mem_we_s = 1'b0;
        endcase
        in_ready_s = (state_s == ST_ACCEPT);
        busy_s     = (state_s == ST_ACCEPT) || (state_s == ST_WRITE) ||
                     (state_s == ST_RDBK)   || (state_s == ST_CHECK);
        done_s     = (state_s == ST_DONE);
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r        <= {ADDR_W{1'b0}};
            full_r        <= 1'b0;
            word_r        <= {INSTR_W{1'b0}};
            last_r        <= 1'b0;
            in_ready_r    <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_re_r      <= 1'b0;
            mem_addr_r    <= {ADDR_W{1'b0}};
            mem_wdata_r   <= {INSTR_W{1'b0}};
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_illegal_r <= 1'b0;
            err_verify_r  <= 1'b0;
            err_full_r    <= 1'b0;
            words_r       <= {(ADDR_W+1){1'b0}};
        end else begin
            addr_r        <= addr_s;
            full_r        <= full_s;
            word_r        <= word_s;
            last_r        <= last_s;
            in_ready_r    <= in_ready_s;
            mem_we_r      <= mem_we_s;
            mem_re_r      <= mem_re_s;
            mem_addr_r    <= mem_addr_s;
            mem_wdata_r   <= mem_wdata_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            err_illegal_r <= err_illegal_s;
            err_verify_r  <= err_verify_s;
            err_full_r    <= err_full_s;
            words_r       <= words_s;
        end
    end

    // A word whose strobe cycle coincides with reset is dropped, so the strobes are
    // qualified by reset rather than waiting for the reset edge to clear them.
    assign mem_we        = mem_we_r & ~reset;
    assign mem_re        = mem_re_r & ~reset;
    assign in_ready      = in_ready_r;
    assign mem_addr      = mem_addr_r;
    assign mem_wdata     = mem_wdata_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign err_illegal   = err_illegal_r;
    assign err_verify    = err_verify_r;
    assign err_full      = err_full_r;
    assign words_written = words_r;

endmodule

// File: tb/tb_prog_image_writer.sv
module tb_prog_image_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, in_valid, in_last;
    logic [3:0] in_op, in_operand;
    logic [7:0] base_addr;
    logic [8:0] mem_rdata = 9'd0;
    int         sel;
    int         bad_addr;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    logic [8:0] mem [0:255] = '{default: 9'd0};

    // instance a: ADDR_W=8 VERIFY=1; b: ADDR_W=3 VERIFY=1; c: ADDR_W=8 VERIFY=0
    logic a_ready, a_we, a_re, a_busy, a_done, a_ei, a_ev, a_ef;
    logic b_ready, b_we, b_re, b_busy, b_done, b_ei, b_ev, b_ef;
    logic c_ready, c_we, c_re, c_busy, c_done, c_ei, c_ev, c_ef;
    logic [7:0] a_addr, c_addr;
    logic [2:0] b_addr;
    logic [8:0] a_wdata, b_wdata, c_wdata, a_words, c_words;
    logic [3:0] b_words;
    logic       a_start, b_start, c_start;
    logic [2:0] b_base;

    assign a_start = start && (sel == 0);
    assign b_start = start && (sel == 1);
    assign c_start = start && (sel == 2);
    assign b_base  = base_addr[2:0];

    prog_image_writer #(.ADDR_W(8), .VERIFY(1)) u_dut_a (
        .clk(clk), .reset(reset), .start(a_start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(a_ready), .in_op(in_op), .in_operand(in_operand),
        .in_last(in_last), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
        .mem_re(a_re), .mem_rdata(mem_rdata), .busy(a_busy), .done(a_done),
        .err_illegal(a_ei), .err_verify(a_ev), .err_full(a_ef), .words_written(a_words));

    prog_image_writer #(.ADDR_W(3), .VERIFY(1)) u_dut_b (
        .clk(clk), .reset(reset), .start(b_start), .base_addr(b_base),
        .in_valid(in_valid), .in_ready(b_ready), .in_op(in_op), .in_operand(in_operand),
        .in_last(in_last), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .mem_re(b_re), .mem_rdata(mem_rdata), .busy(b_busy), .done(b_done),
        .err_illegal(b_ei), .err_verify(b_ev), .err_full(b_ef), .words_written(b_words));

    prog_image_writer #(.ADDR_W(8), .VERIFY(0)) u_dut_c (
        .clk(clk), .reset(reset), .start(c_start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(c_ready), .in_op(in_op), .in_operand(in_operand),
        .in_last(in_last), .mem_we(c_we), .mem_addr(c_addr), .mem_wdata(c_wdata),
        .mem_re(c_re), .mem_rdata(mem_rdata), .busy(c_busy), .done(c_done),
        .err_illegal(c_ei), .err_verify(c_ev), .err_full(c_ef), .words_written(c_words));

    logic       cur_ready, cur_we, cur_re, cur_busy, cur_done, cur_ei, cur_ev, cur_ef;
    logic [7:0] cur_addr;
    logic [8:0] cur_wdata, cur_words;

    always_comb begin
        {cur_ready, cur_we, cur_re, cur_busy, cur_done, cur_ei, cur_ev, cur_ef} =
            {a_ready, a_we, a_re, a_busy, a_done, a_ei, a_ev, a_ef};
        cur_addr  = a_addr;
        cur_wdata = a_wdata;
        cur_words = a_words;
        case (sel)
            1: begin
                {cur_ready, cur_we, cur_re, cur_busy, cur_done, cur_ei, cur_ev, cur_ef} =
                    {b_ready, b_we, b_re, b_busy, b_done, b_ei, b_ev, b_ef};
                cur_addr  = {5'd0, b_addr};
                cur_wdata = b_wdata;
                cur_words = {5'd0, b_words};
            end
            2: begin
                {cur_ready, cur_we, cur_re, cur_busy, cur_done, cur_ei, cur_ev, cur_ef} =
                    {c_ready, c_we, c_re, c_busy, c_done, c_ei, c_ev, c_ef};
                cur_addr  = c_addr;
                cur_wdata = c_wdata;
                cur_words = c_words;
            end
            default: ;
        endcase
    end

    // imem model: synchronous write, registered read; one address may be set to corrupt bit 0 on read
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cur_we) mem[cur_addr] <= cur_wdata;
        if (cur_re) mem_rdata <= (int'(cur_addr) == bad_addr) ? (mem[cur_addr] ^ 9'h001) : mem[cur_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed { logic [3:0] op; logic [3:0] opnd; logic last; } rec_t;
    typedef struct packed { logic [7:0] addr; logic [8:0] data; } wr_t;
    rec_t recs[$];
    wr_t  wq[$];
    int   wcyc[$];
    int   m_nacc, m_nw;
    bit   m_done, m_ill, m_ver, m_full;
    wr_t  e;

    function automatic rec_t mk(input int op, input int opnd, input bit last);
        rec_t r;
        r.op = op[3:0]; r.opnd = opnd[3:0]; r.last = last;
        return r;
    endfunction

    // Walks the record list: which records get consumed, which words land where,
    // and how the image ends.
    task automatic model(input int base, input int depth);
        int  a;
        wr_t w;
        a = base; m_nacc = 0; m_nw = 0;
        m_done = 0; m_ill = 0; m_ver = 0; m_full = 0;
        wq.delete();
        for (int i = 0; i < recs.size(); i++) begin
            m_nacc++;
            if (recs[i].op >= 4'd14) begin m_ill = 1; break; end
            if (a >= depth) begin m_full = 1; break; end
            w.addr = a[7:0];
            w.data = {recs[i].opnd, recs[i].op, 1'b0};
            wq.push_back(w);
            m_nw++;
            if (a == bad_addr) begin m_ver = 1; break; end
            if (recs[i].last) begin m_done = 1; break; end
            a++;
        end
    endtask

    // per-cycle compare of imem strobes against the model's expected write sequence
    always @(negedge clk) begin
        if (cur_we || cur_re) chk("we_re_exclusive", {31'd0, cur_we & cur_re}, 32'd0);
        if (cur_we) begin
            wcyc.push_back(cyc);
            chk("write_expected", {31'd0, wq.size() > 0}, 32'd1);
            if (wq.size() > 0) begin
                e = wq.pop_front();
                chk("wr_addr", {24'd0, cur_addr}, {24'd0, e.addr});
                chk("wr_data", {23'd0, cur_wdata}, {23'd0, e.data});
                if (sel == 2 && wq.size() == 0 && m_done) chk("done_with_last_we", {31'd0, cur_done}, 32'd1);
            end
        end
    end

    task automatic run_image(input int s, input int base);
        bit acc;
        sel = s;
        wcyc.delete();
        @(negedge clk);
        base_addr = base[7:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ready", {31'd0, cur_ready}, 32'd1);
        chk("start_busy", {31'd0, cur_busy}, 32'd1);
        chk("start_clear", {28'd0, cur_done, cur_ei, cur_ev, cur_ef}, 32'd0);
        chk("start_words", {23'd0, cur_words}, 32'd0);
        for (int i = 0; i < m_nacc; i++) begin
            in_valid = 1'b1; in_op = recs[i].op; in_operand = recs[i].opnd; in_last = recs[i].last;
            acc = 0;
            for (int n = 0; n < 12 && !acc; n++) begin
                if (cur_ready) acc = 1;
                @(negedge clk);
            end
            chk("handshake", {31'd0, acc}, 32'd1);
            if (!acc) break;
        end
        in_valid = 1'b0; in_last = 1'b0;
        for (int n = 0; n < 12; n++) begin
            if (cur_done || cur_ei || cur_ev || cur_ef) break;
            @(negedge clk);
        end
        @(negedge clk);
        chk("end_done", {31'd0, cur_done}, {31'd0, m_done});
        chk("end_err_illegal", {31'd0, cur_ei}, {31'd0, m_ill});
        chk("end_err_verify", {31'd0, cur_ev}, {31'd0, m_ver});
        chk("end_err_full", {31'd0, cur_ef}, {31'd0, m_full});
        chk("end_words", {23'd0, cur_words}, m_nw);
        chk("end_busy", {31'd0, cur_busy}, 32'd0);
        chk("writes_all_seen", wq.size(), 32'd0);
        // a record offered after the image has ended must not be taken
        in_valid = 1'b1; in_op = 4'd0; in_operand = 4'd0;
        for (int n = 0; n < 3; n++) begin
            chk("closed_ready", {31'd0, cur_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_op = 4'd0; in_operand = 4'd0; base_addr = 8'd0; sel = 0; bad_addr = -1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("reset_ctl", {24'd0, cur_ready, cur_we, cur_re, cur_busy, cur_done, cur_ei, cur_ev, cur_ef}, 32'd0);
            chk("reset_words", {23'd0, cur_words}, 32'd0);
            chk("reset_addr", {24'd0, cur_addr}, 32'd0);
        end
        sel = 0;
        reset = 1'b0;
        @(negedge clk);

        // 1: verify mode, two words at 0x10
        recs.delete(); recs.push_back(mk(3, 3, 0)); recs.push_back(mk(4, 5, 1));
        model(32'h10, 256);
        chk("pin_t1_w0", {15'd0, wq[0]}, {15'd0, 8'h10, 9'h066});
        chk("pin_t1_w1", {15'd0, wq[1]}, {15'd0, 8'h11, 9'h0A8});
        run_image(0, 32'h10);
        chk("t1_mem10", {23'd0, mem[8'h10]}, 32'h066);
        chk("t1_mem11", {23'd0, mem[8'h11]}, 32'h0A8);
        chk("t1_words", {23'd0, cur_words}, 32'd2);
        chk("t1_done", {31'd0, cur_done}, 32'd1);

        // 2: read-back of 0x11 corrupted
        bad_addr = 32'h11;
        recs.delete(); recs.push_back(mk(3, 3, 0)); recs.push_back(mk(4, 5, 0)); recs.push_back(mk(5, 1, 1));
        model(32'h10, 256);
        chk("pin_t2_ver", {31'd0, m_ver}, 32'd1);
        run_image(0, 32'h10);
        chk("t2_err_verify", {31'd0, cur_ev}, 32'd1);
        chk("t2_no_write_12", {23'd0, mem[8'h12]}, 32'd0);
        bad_addr = -1;

        // 3: illegal opcode as second record, then restart at the same base
        recs.delete(); recs.push_back(mk(0, 7, 0)); recs.push_back(mk(14, 2, 1));
        model(32'h20, 256);
        chk("pin_t3_nw", m_nw, 32'd1);
        run_image(0, 32'h20);
        chk("t3_err_illegal", {31'd0, cur_ei}, 32'd1);
        chk("t3_mem21", {23'd0, mem[8'h21]}, 32'd0);
        recs.delete(); recs.push_back(mk(6, 2, 1));
        model(32'h20, 256);
        run_image(0, 32'h20);
        chk("t3_mem20_rewritten", {23'd0, mem[8'h20]}, 32'h04C);

        // 4: 8-word memory, base 6: overflow, then exact fit
        recs.delete(); recs.push_back(mk(1, 1, 0)); recs.push_back(mk(2, 2, 0)); recs.push_back(mk(7, 3, 0));
        model(6, 8);
        chk("pin_t4_full", {31'd0, m_full}, 32'd1);
        run_image(1, 6);
        chk("t4_err_full", {31'd0, cur_ef}, 32'd1);
        chk("t4_words", {23'd0, cur_words}, 32'd2);
        recs.delete(); recs.push_back(mk(1, 1, 0)); recs.push_back(mk(2, 2, 1));
        model(6, 8);
        run_image(1, 6);
        chk("t4_fit_done", {28'd0, cur_done, cur_ei, cur_ev, cur_ef}, 32'h8);

        // 5: write-only, back-to-back
        recs.delete();
        recs.push_back(mk(8, 1, 0)); recs.push_back(mk(9, 2, 0));
        recs.push_back(mk(10, 3, 0)); recs.push_back(mk(11, 4, 1));
        model(32'h80, 256);
        run_image(2, 32'h80);
        chk("t5_nwrites", wcyc.size(), 32'd4);
        if (wcyc.size() == 4) chk("t5_consecutive", wcyc[3] - wcyc[0], 32'd3);
        chk("t5_mem83", {23'd0, mem[8'h83]}, 32'h096);

        // 6: reset in the cycle after a handshake drops the word
        sel = 0;
        wq.delete();
        @(negedge clk);
        base_addr = 8'h40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6_ready", {31'd0, cur_ready}, 32'd1);
        in_valid = 1'b1; in_op = 4'd3; in_operand = 4'd3; in_last = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("t6_we_dropped", {31'd0, cur_we}, 32'd0);
        chk("t6_re_low", {31'd0, cur_re}, 32'd0);
        @(negedge clk);
        chk("t6_outs", {24'd0, cur_ready, cur_we, cur_re, cur_busy, cur_done, cur_ei, cur_ev, cur_ef}, 32'd0);
        chk("t6_addr", {24'd0, cur_addr}, 32'd0);
        chk("t6_wdata", {23'd0, cur_wdata}, 32'd0);
        chk("t6_words", {23'd0, cur_words}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_idle", {30'd0, cur_ready, cur_busy}, 32'd0);
        chk("t6_mem40", {23'd0, mem[8'h40]}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
